// File: rtl/drop_pkg.sv
// Shared types and constants for the column-drop board engine.
package drop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FALLING  = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_UNDO     = 2'd3
    } state_t;

    localparam int unsigned EMPTY = 0;

    // Index width that stays legal for single-entry dimensions.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drop_engine_undo_stack.sv
// Circular LIFO of recent moves; a push when full silently replaces the oldest entry.
module undo_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     top_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] top_ptr_s;
    logic [PTR_W-1:0] wr_next_s;
    logic [CNT_W-1:0] count_r;

    // Wrap-around neighbours of the write pointer
    always_comb begin
        top_ptr_s = (wr_ptr_r == '0) ? LAST : wr_ptr_r - PTR_W'(1);
        wr_next_s = (wr_ptr_r == LAST) ? '0 : wr_ptr_r + PTR_W'(1);
    end

    // Storage, pointer and saturating occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_next_s;
            count_r         <= (count_r == CNT_W'(DEPTH)) ? count_r : count_r + CNT_W'(1);
        end else if (pop && (count_r != '0)) begin
            wr_ptr_r <= top_ptr_s;
            count_r  <= count_r - CNT_W'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
            count_r  <= count_r;
        end
    end

    assign top_data = mem_r[top_ptr_s];
    assign empty    = (count_r == '0);
    assign count    = count_r;

endmodule

// File: rtl/drop_engine.sv
// Gravity-drop board engine: queues column requests, animates the falling piece,
// lands it, enforces a post-move lockout and supports multi-level undo.
module drop_engine
    import drop_pkg::*;
#(
    parameter int ROWS            = 6,
    parameter int COLS            = 7,
    parameter int PW              = 2,
    parameter int FALL_CYCLES     = 2_500_000,
    parameter int COOLDOWN_CYCLES = 12_500_000,
    parameter int UNDO_DEPTH      = 8,
    localparam int RW             = clog2_min1(ROWS),
    localparam int CW             = clog2_min1(COLS),
    localparam int BW             = ROWS * COLS * PW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [COLS-1:0] col_req,
    input  logic            undo_req,
    input  logic [PW-1:0]   player,
    input  logic            game_over,
    output logic            inserted,
    output logic            rejected,
    output logic            undone,
    output logic            busy,
    output logic            fall_valid,
    output logic [RW-1:0]   fall_row,
    output logic [CW-1:0]   fall_col,
    output logic [BW-1:0]   board_out
);

    localparam int CNT_MAX = (FALL_CYCLES > COOLDOWN_CYCLES) ? FALL_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W   = clog2_min1(CNT_MAX + 1);
    localparam int HC_W    = $clog2(UNDO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_CYCLES - 1);
    // A zero lockout still spends the single cycle in COOLDOWN.
    localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
    localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);

    state_t            state_r, state_nx_s;
    logic [COLS-1:0]   pend_r, serve_mask_s;
    logic              undo_pend_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [RW-1:0]     fall_row_r, below_row_s;
    logic [CW-1:0]     fall_col_r, sel_col_s;
    logic [PW-1:0]     piece_r;
    logic [BW-1:0]     board_r;
    logic              inserted_r, rejected_r, undone_r, busy_r, fall_valid_r;
    logic              sel_any_s, can_descend_s, fall_step_s, cd_done_s;
    logic              do_start_s, do_reject_s, do_descend_s, do_land_s, do_pop_s;
    logic [RW+CW-1:0]  top_s;
    logic              hist_empty_s, hist_avail_s;
    logic [HC_W-1:0]   hist_count_s;

    function automatic logic [PW-1:0] cell_at(input logic [BW-1:0] b, input int r, input int c);
        return b[(r * COLS + c) * PW +: PW];
    endfunction

    undo_stack #(
        .DEPTH (UNDO_DEPTH),
        .W     (RW + CW),
        .CNT_W (HC_W)
    ) u_hist (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (do_land_s),
        .push_data ({fall_row_r, fall_col_r}),
        .pop       (do_pop_s),
        .top_data  (top_s),
        .empty     (hist_empty_s),
        .count     (hist_count_s)
    );

    // Lowest-index pending column and fall/cooldown qualifiers
    always_comb begin
        sel_col_s = '0;
        sel_any_s = |pend_r;
        for (int i = COLS - 1; i >= 0; i--) begin
            sel_col_s = pend_r[i] ? CW'(i) : sel_col_s;
        end
        below_row_s   = (fall_row_r < ROW_LAST) ? fall_row_r + RW'(1) : fall_row_r;
        can_descend_s = (fall_row_r < ROW_LAST) &&
                        (cell_at(board_r, int'(below_row_s), int'(fall_col_r)) == PW'(EMPTY));
        fall_step_s   = (cnt_r == FALL_LAST);
        cd_done_s     = (cnt_r == CD_LAST);
        // Pop only when both occupancy views agree there is something to undo.
        hist_avail_s  = !hist_empty_s && (hist_count_s != '0);
    end

    // Next-state and per-cycle action decode
    always_comb begin
        state_nx_s   = state_r;
        serve_mask_s = '0;
        do_start_s   = 1'b0;
        do_reject_s  = 1'b0;
        do_descend_s = 1'b0;
        do_land_s    = 1'b0;
        do_pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (undo_pend_r) begin
                    state_nx_s = ST_UNDO;
                end else if (sel_any_s && !game_over) begin
                    serve_mask_s = COLS'(1) << sel_col_s;
                    if (cell_at(board_r, 0, int'(sel_col_s)) != PW'(EMPTY)) begin
                        do_reject_s = 1'b1;
                    end else begin
                        do_start_s = 1'b1;
                        state_nx_s = ST_FALLING;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FALLING: begin
                if (game_over) begin
                    state_nx_s = ST_IDLE;
                end else if (fall_step_s) begin
                    if (can_descend_s) begin
                        do_descend_s = 1'b1;
                    end else begin
                        do_land_s  = 1'b1;
                        state_nx_s = ST_COOLDOWN;
                    end
                end else begin
                    state_nx_s = ST_FALLING;
                end
            end
            ST_COOLDOWN: begin
                if (game_over || cd_done_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_COOLDOWN;
                end
            end
            ST_UNDO: begin
                if (hist_avail_s) begin
                    do_pop_s   = 1'b1;
                    state_nx_s = ST_COOLDOWN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Request capture, shared timer, falling piece, board and event outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r       <= '0;
            undo_pend_r  <= 1'b0;
            cnt_r        <= '0;
            fall_row_r   <= '0;
            fall_col_r   <= '0;
            piece_r      <= '0;
            board_r      <= '0;
            inserted_r   <= 1'b0;
            rejected_r   <= 1'b0;
            undone_r     <= 1'b0;
            busy_r       <= 1'b0;
            fall_valid_r <= 1'b0;
        end else begin
            pend_r      <= game_over ? '0 : ((pend_r & ~serve_mask_s) | col_req);
            undo_pend_r <= ((state_r == ST_UNDO) ? 1'b0 : undo_pend_r) | undo_req;
            if ((state_nx_s != state_r) || (state_r == ST_IDLE) ||
                ((state_r == ST_FALLING) && fall_step_s)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (do_start_s) begin
                fall_row_r <= '0;
                fall_col_r <= sel_col_s;
                piece_r    <= player;
            end else if (do_descend_s) begin
                fall_row_r <= fall_row_r + RW'(1);
            end else begin
                fall_row_r <= fall_row_r;
            end
            if (do_land_s) begin
                board_r[(int'(fall_row_r) * COLS + int'(fall_col_r)) * PW +: PW] <= piece_r;
            end else if (do_pop_s) begin
                board_r[(int'(top_s[CW +: RW]) * COLS + int'(top_s[CW-1:0])) * PW +: PW] <= PW'(EMPTY);
            end else begin
                board_r <= board_r;
            end
            inserted_r   <= do_land_s;
            rejected_r   <= do_reject_s;
            undone_r     <= do_pop_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            fall_valid_r <= (state_nx_s == ST_FALLING);
        end
    end

    assign inserted   = inserted_r;
    assign rejected   = rejected_r;
    assign undone     = undone_r;
    assign busy       = busy_r;
    assign fall_valid = fall_valid_r;
    assign fall_row   = fall_row_r;
    assign fall_col   = fall_col_r;
    assign board_out  = board_r;

endmodule
